uart_rx_param: RTL and testbench

Parametrised UART receiver: it oversamples an asynchronous serial line with a single system clock and deframes configurable-width characters with optional parity and one or two stop bits. It reports each character to a downstream consumer over a valid/ready handshake, with per-character parity and framing status and a sticky overrun indication. It sits between the board RX pin and the byte-consuming logic (command parser or FIFO), replacing the fixed 8N1 receiver.

---
 rtl/uart_rx_param.sv | 149 ++++++++++++++
 tb/tb_uart_rx_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready character output.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each mid-bit sample.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 22274,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle after nominal mid-bit so the vote window straddles it;
  // the per-bit period is unchanged, every decision simply shifts one cycle later.
  localparam int START_DONE = CLKS_PER_BIT / 2;
`else
  localparam int START_DONE = CLKS_PER_BIT / 2 - 1;
`endif
  localparam logic [CW-1:0] START_END = CW'(START_DONE);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               state, state_nxt;
  logic                 rx_p0, rx_p1;
  logic                 rx_s;
  logic                 sample;
  logic                 tick;
  logic                 complete;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q;
  logic                 frame_err_q;

  // Stage p0/p1: metastability synchroniser, idles high
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rx_hist;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) rx_hist <= 2'b11;
    else            rx_hist <= {rx_hist[0], rx_s};
  end

  assign sample = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!rx_s) state_nxt = S_START;
      S_START:  if (tick) state_nxt = sample ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_idx == LAST_DATA) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP:   if (tick && bit_idx == LAST_STOP) state_nxt = sample ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (state != S_IDLE);
    tick     = (state == S_START) ? (cnt == START_END) : (cnt == BIT_END);
    complete = (state == S_STOP) && tick && (bit_idx == LAST_STOP);
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (state == S_IDLE || state == S_BREAK || tick) cnt <= '0;
      else                                              cnt <= cnt + CW'(1);

      case (state)
        S_START: if (tick) begin
          bit_idx     <= '0;
          par_err_q   <= 1'b0;
          frame_err_q <= 1'b0;
        end
        S_DATA: if (tick) begin
          shreg   <= {sample, shreg[DATA_BITS-1:1]};
          bit_idx <= (bit_idx == LAST_DATA) ? '0 : bit_idx + IW'(1);
        end
        S_PARITY: if (tick) par_err_q <= ^shreg ^ sample ^ (PARITY == 1);
        S_STOP: if (tick) begin
          bit_idx <= bit_idx + IW'(1);
          if (!sample) frame_err_q <= 1'b1;
        end
        default: ;
      endcase

      // A completing character may reuse the slot being handed off this cycle
      if (complete) begin
        if (!o_valid || i_ready) begin
          o_data       <= shreg;
          o_parity_err <= (PARITY != 0) && par_err_q;
          o_frame_err  <= frame_err_q | ~sample;
          o_valid      <= 1'b1;
        end else begin
          o_overrun    <= 1'b1;
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1 and 7E2 instances at 16 clocks per bit.
module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .i_reset_n(rst_n), .i_rx(rx_a), .o_data(data_a), .o_valid(valid_a),
    .i_ready(ready_a), .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_overrun(ovr_a),
    .o_busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .i_reset_n(rst_n), .i_rx(rx_b), .o_data(data_b), .o_valid(valid_b),
    .i_ready(ready_b), .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_overrun(ovr_b),
    .o_busy(busy_b));

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    bit         sel;
    logic [8:0] data;
    bit         par_bit;
    bit         last_stop;
    logic       perr;
    logic       ferr;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  vec_t vecs[10];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [8:0] data, input int nbits, input bit use_par,
                      input bit par_bit, input int nstop, input bit last_stop);
    drive_bit(sel, 1'b0, CPB);
    for (int i = 0; i < nbits; i++) drive_bit(sel, data[i], CPB);
    if (use_par) drive_bit(sel, par_bit, CPB);
    for (int s = 0; s < nstop; s++) drive_bit(sel, (s == nstop - 1) ? last_stop : 1'b1, CPB);
    drive_bit(sel, 1'b1, GAP);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each character as the consumer accepts it
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_a === 1'b1 && ready_a === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got data %0h expected no character", data_a);
      end else begin
        ea = q_a.pop_front();
        check("a_data", 32'(data_a), 32'(ea.data));
        check("a_perr", 32'(perr_a), 32'(ea.perr));
        check("a_ferr", 32'(ferr_a), 32'(ea.ferr));
      end
    end
    if (rst_n === 1'b1 && valid_b === 1'b1 && ready_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got data %0h expected no character", data_b);
      end else begin
        eb = q_b.pop_front();
        check("b_data", 32'(data_b), 32'(eb.data));
        check("b_perr", 32'(perr_b), 32'(eb.perr));
        check("b_ferr", 32'(ferr_b), 32'(eb.ferr));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 9'h0A5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 9'h0FF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 9'h081, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 9'h03C, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 9'h041, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 9'h041, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 9'h07F, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 9'h07F, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 9'h02A, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_data", 32'(data_a), 32'h0);  check("rst_a_valid", 32'(valid_a), 32'h0);
    check("rst_a_perr", 32'(perr_a), 32'h0);  check("rst_a_ferr", 32'(ferr_a), 32'h0);
    check("rst_a_ovr", 32'(ovr_a), 32'h0);    check("rst_a_busy", 32'(busy_a), 32'h0);
    check("rst_b_data", 32'(data_b), 32'h0);  check("rst_b_valid", 32'(valid_b), 32'h0);
    check("rst_b_perr", 32'(perr_b), 32'h0);  check("rst_b_ferr", 32'(ferr_b), 32'h0);
    check("rst_b_ovr", 32'(ovr_b), 32'h0);    check("rst_b_busy", 32'(busy_b), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 5-cycle glitch: busy rises 3 cycles after the edge, start check rejects it
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_latency_pre", 32'(busy_a), 32'h0);
    @(negedge clk);
    check("busy_latency_post", 32'(busy_a), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_busy", 32'(busy_a), 32'h0);
    check("glitch_valid", 32'(valid_a), 32'h0);

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].sel) begin
        q_b.push_back('{vecs[v].data, vecs[v].perr, vecs[v].ferr});
        send(1'b1, vecs[v].data, 7, 1'b1, vecs[v].par_bit, 2, vecs[v].last_stop);
      end else begin
        q_a.push_back('{vecs[v].data, vecs[v].perr, vecs[v].ferr});
        send(1'b0, vecs[v].data, 8, 1'b0, 1'b0, 1, vecs[v].last_stop);
      end
    end
    wait_drain();

    // Overrun: second character dropped while the first is held
    ready_a = 1'b0;
    q_a.push_back('{9'h011, 1'b0, 1'b0});
    send(1'b0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
    check("ovr_not_yet", 32'(ovr_a), 32'h0);
    send(1'b0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
    check("ovr_hold_data", 32'(data_a), 32'h11);
    check("ovr_hold_valid", 32'(valid_a), 32'h1);
    check("ovr_set", 32'(ovr_a), 32'h1);
    ready_a = 1'b1;
    wait_drain();
    check("ovr_valid_clear", 32'(valid_a), 32'h0);
    check("ovr_sticky", 32'(ovr_a), 32'h1);

    // Second stop low then line held low: BREAK until the line returns high
    q_b.push_back('{9'h03C, 1'b0, 1'b1});
    drive_bit(1'b1, 1'b0, CPB);
    for (int i = 0; i < 7; i++) drive_bit(1'b1, (i >= 2 && i <= 5), CPB);
    drive_bit(1'b1, 1'b0, CPB);
    drive_bit(1'b1, 1'b1, CPB);
    drive_bit(1'b1, 1'b0, CPB + 48);
    check("break_busy", 32'(busy_b), 32'h1);
    drive_bit(1'b1, 1'b1, 4);
    check("break_exit", 32'(busy_b), 32'h0);
    q_b.push_back('{9'h055, 1'b0, 1'b0});
    send(1'b1, 9'h055, 7, 1'b1, 1'b0, 2, 1'b1);
    wait_drain();

`ifdef UART_RX_MAJORITY_EN
    // One-cycle spike inside data bit 3 is outvoted
    q_a.push_back('{9'h000, 1'b0, 1'b0});
    drive_bit(1'b0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0, CPB);
    drive_bit(1'b0, 1'b0, 9);
    drive_bit(1'b0, 1'b1, 1);
    drive_bit(1'b0, 1'b0, CPB - 10);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0, CPB);
    drive_bit(1'b0, 1'b1, CPB + GAP);
    wait_drain();
`endif

    // Reset during data bit 4 discards the frame and clears everything
    drive_bit(1'b0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1, CPB);
    drive_bit(1'b0, 1'b0, 8);
    check("mid_busy", 32'(busy_a), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mrst_data", 32'(data_a), 32'h0);   check("mrst_valid", 32'(valid_a), 32'h0);
    check("mrst_perr", 32'(perr_a), 32'h0);   check("mrst_ferr", 32'(ferr_a), 32'h0);
    check("mrst_ovr", 32'(ovr_a), 32'h0);     check("mrst_busy", 32'(busy_a), 32'h0);
    rx_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q_a.push_back('{9'h0F0, 1'b0, 1'b0});
    send(1'b0, 9'h0F0, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_drain();
    check("final_ovr", 32'(ovr_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
